// File: rtl/vdf_modsq_iter.sv
// vdf_modsq_iter: y = x^(2^T) mod N by repeated bit-serial interleaved modular squaring.
// Define VDF_ITER_SNAPSHOT_EN to add per-iteration snapshot outputs (snap_valid/snap_val/snap_idx).
module vdf_modsq_iter #(
  parameter int MOD_LEN = 128,
  parameter int ITER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MOD_LEN-1:0] modulus_in,
  input  logic [MOD_LEN-1:0] x_in,
  input  logic [ITER_W-1:0]  iters_in,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [MOD_LEN-1:0] y_out,
  output logic [ITER_W-1:0]  iter_cnt
`ifdef VDF_ITER_SNAPSHOT_EN
  ,
  output logic               snap_valid,
  output logic [MOD_LEN-1:0] snap_val,
  output logic [ITER_W-1:0]  snap_idx
`endif
);
  localparam int BW = $clog2(MOD_LEN);
  localparam int TW = MOD_LEN + 2;
  typedef enum logic [1:0] {IDLE, MUL, NEXT, DONE} state_t;
  state_t state_q, state_d;
  logic [MOD_LEN-1:0] n_q, n_d, x_q, x_d, acc_q, acc_d, y_q, y_d, red;
  logic [ITER_W-1:0] t_q, t_d, iter_q, iter_d, iter_inc;
  logic [BW-1:0] b_q, b_d;
  logic err_q, err_d;
  logic [TW-1:0] sum, n1, n2;
  // acc < N and x < N keep sum below 3N, so at most two subtractions of N are needed
  always_comb begin
    n1 = {2'b00, n_q};
    n2 = {1'b0, n_q, 1'b0};
    sum = {1'b0, acc_q, 1'b0} + (x_q[b_q] ? {2'b00, x_q} : '0);
    red = MOD_LEN'(sum >= n2 ? sum - n2 : sum >= n1 ? sum - n1 : sum);
    iter_inc = iter_q + ITER_W'(1);
  end
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    x_d = x_q;
    t_d = t_q;
    acc_d = acc_q;
    b_d = b_q;
    y_d = y_q;
    iter_d = iter_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        n_d = modulus_in;
        x_d = x_in;
        t_d = iters_in;
        iter_d = '0;
        err_d = 1'b0;
        acc_d = '0;
        b_d = BW'(MOD_LEN - 1);
        if (modulus_in < MOD_LEN'(2) || x_in >= modulus_in) begin
          err_d = 1'b1;
          state_d = DONE;
        end else if (iters_in == '0) begin
          y_d = x_in;
          state_d = DONE;
        end else state_d = MUL;
      end
      MUL: if (abort) state_d = IDLE;
      else begin
        acc_d = red;
        b_d = b_q - 1'b1;
        state_d = b_q == '0 ? NEXT : MUL;
      end
      NEXT: if (abort) state_d = IDLE;
      else begin
        x_d = acc_q;
        iter_d = iter_inc;
        acc_d = '0;
        b_d = BW'(MOD_LEN - 1);
        y_d = iter_inc == t_q ? acc_q : y_q;
        state_d = iter_inc == t_q ? DONE : MUL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q <= '0;
      x_q <= '0;
      t_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      y_q <= '0;
      iter_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      x_q <= x_d;
      t_q <= t_d;
      acc_q <= acc_d;
      b_q <= b_d;
      y_q <= y_d;
      iter_q <= iter_d;
      err_q <= err_d;
    end
  end
  assign busy = state_q == MUL || state_q == NEXT;
  assign done = state_q == DONE;
  assign err = err_q;
  assign y_out = y_q;
  assign iter_cnt = iter_q;
`ifdef VDF_ITER_SNAPSHOT_EN
  logic snap_q, snap_d;
  always_comb snap_d = state_q == NEXT && !abort;
  always_ff @(posedge clk) snap_q <= reset ? 1'b0 : snap_d;
  // x_q and iter_q already hold the freshly completed iteration while the pulse is high
  assign snap_valid = snap_q;
  assign snap_val = x_q;
  assign snap_idx = iter_q;
`endif
endmodule

// File: tb/tb_vdf_modsq_iter.sv
// tb_vdf_modsq_iter: checks vdf_modsq_iter at MOD_LEN=8 and MOD_LEN=128 against a modular-power model.
module tb_vdf_modsq_iter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic start, abort;
  logic [7:0] n8, x8, y8;
  logic [31:0] t8, ic8;
  logic busy8, done8, err8;
  logic start_w, abort_w;
  logic [127:0] nw, xw, yw;
  logic [31:0] tw, icw;
  logic busy_w, done_w, err_w;
  int checks = 0;
  int failures = 0;
`ifdef VDF_ITER_SNAPSHOT_EN
  logic sv8, sv_w;
  logic [7:0] sval8;
  logic [127:0] sval_w;
  logic [31:0] sidx8, sidx_w;
  logic [7:0] snaps8[$];
`endif
  vdf_modsq_iter #(.MOD_LEN(8), .ITER_W(32)) dut8 (
    .clk(clk), .reset(reset), .start(start), .modulus_in(n8), .x_in(x8), .iters_in(t8),
    .abort(abort), .busy(busy8), .done(done8), .err(err8), .y_out(y8), .iter_cnt(ic8)
`ifdef VDF_ITER_SNAPSHOT_EN
    , .snap_valid(sv8), .snap_val(sval8), .snap_idx(sidx8)
`endif
  );
  vdf_modsq_iter dut_w (
    .clk(clk), .reset(reset), .start(start_w), .modulus_in(nw), .x_in(xw), .iters_in(tw),
    .abort(abort_w), .busy(busy_w), .done(done_w), .err(err_w), .y_out(yw), .iter_cnt(icw)
`ifdef VDF_ITER_SNAPSHOT_EN
    , .snap_valid(sv_w), .snap_val(sval_w), .snap_idx(sidx_w)
`endif
  );

  function automatic logic [127:0] ref_pow(input logic [127:0] n, input logic [127:0] x, input int t);
    logic [255:0] a;
    a = {128'b0, x};
    for (int i = 0; i < t; i++) a = (a * a) % {128'b0, n};
    return a[127:0];
  endfunction

  task automatic wait_done8(output int cyc, output int bcnt);
    cyc = 1;
    bcnt = 0;
    while (1) begin
`ifdef VDF_ITER_SNAPSHOT_EN
      if (sv8) snaps8.push_back(sval8);
`endif
      if (done8 || cyc >= 2000) break;
      bcnt += int'(busy8);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run8(input logic [7:0] n, input logic [7:0] x, input logic [31:0] t, output int cyc, output int bcnt);
`ifdef VDF_ITER_SNAPSHOT_EN
    snaps8.delete();
`endif
    @(negedge clk);
    n8 = n; x8 = x; t8 = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done8(cyc, bcnt);
  endtask

  task automatic run_w(input logic [127:0] n, input logic [127:0] x, input logic [31:0] t, output int cyc);
    @(negedge clk);
    nw = n; xw = x; tw = t; start_w = 1'b1;
    @(negedge clk);
    start_w = 1'b0;
    cyc = 1;
    while (!done_w && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy8); end
    checks++; if (done8 !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done8); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err8); end
    checks++; if (y8 !== 8'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y8); end
    checks++; if (ic8 !== 32'd0) begin failures++; $display("FAIL reset_iter got=%0d exp=0", ic8); end
    checks++; if (yw !== 128'd0 || busy_w !== 1'b0) begin failures++; $display("FAIL reset_wide y=%h busy=%b exp 0/0", yw, busy_w); end
  endtask

  task automatic test_basic;
    int cyc, bc;
    logic [7:0] e;
    run8(8'd221, 8'd5, 32'd3, cyc, bc);
    e = 8'(ref_pow(128'd221, 128'd5, 3));
    checks++; if (cyc !== 28) begin failures++; $display("FAIL basic_latency got=%0d exp=28", cyc); end
    checks++; if (y8 !== e) begin failures++; $display("FAIL basic_y got=%0d exp=%0d", y8, e); end
    checks++; if (err8 !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err8); end
    checks++; if (ic8 !== 32'd3) begin failures++; $display("FAIL basic_iter got=%0d exp=3", ic8); end
    checks++; if (bc !== 27) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=27", bc); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b exp=0", busy8); end
`ifdef VDF_ITER_SNAPSHOT_EN
    checks++; if (snaps8.size() !== 3) begin failures++; $display("FAIL snap_count got=%0d exp=3", snaps8.size()); end
    for (int i = 0; i < snaps8.size(); i++) begin
      e = 8'(ref_pow(128'd221, 128'd5, i + 1));
      checks++; if (snaps8[i] !== e) begin failures++; $display("FAIL snap_val[%0d] got=%0d exp=%0d", i, snaps8[i], e); end
    end
`endif
    @(negedge clk);
    checks++; if (done8 !== 1'b0 || y8 !== e) begin failures++; $display("FAIL basic_hold done=%b y=%0d exp done=0 y=%0d", done8, y8, e); end
  endtask

  task automatic test_zero_iter_and_err;
    int cyc, bc;
    run8(8'd221, 8'd7, 32'd0, cyc, bc);
    checks++; if (cyc !== 1 || y8 !== 8'd7 || err8 !== 1'b0) begin failures++; $display("FAIL t0 got cyc=%0d y=%0d err=%b exp 1/7/0", cyc, y8, err8); end
    checks++; if (bc !== 0 || busy8 !== 1'b0) begin failures++; $display("FAIL t0_busy got cnt=%0d busy=%b exp 0/0", bc, busy8); end
    run8(8'd221, 8'd221, 32'd3, cyc, bc);
    checks++; if (cyc !== 1 || err8 !== 1'b1 || y8 !== 8'd7) begin failures++; $display("FAIL err_x_ge_n got cyc=%0d err=%b y=%0d exp 1/1/7", cyc, err8, y8); end
    checks++; if (bc !== 0 || ic8 !== 32'd0) begin failures++; $display("FAIL err_busy got cnt=%0d iter=%0d exp 0/0", bc, ic8); end
    @(negedge clk);
    checks++; if (err8 !== 1'b1) begin failures++; $display("FAIL err_hold got=%b exp=1", err8); end
    run8(8'd1, 8'd0, 32'd2, cyc, bc);
    checks++; if (cyc !== 1 || err8 !== 1'b1 || y8 !== 8'd7) begin failures++; $display("FAIL err_n_lt_2 got cyc=%0d err=%b y=%0d exp 1/1/7", cyc, err8, y8); end
  endtask

  task automatic test_random;
    int cyc, bc, nn, xx, tt;
    logic [7:0] e;
    for (int i = 0; i < 6; i++) begin
      nn = int'($urandom_range(255, 2));
      xx = int'($urandom_range(nn - 1, 0));
      tt = int'($urandom_range(4, 1));
      run8(8'(nn), 8'(xx), 32'(tt), cyc, bc);
      e = 8'(ref_pow(128'(nn), 128'(xx), tt));
      checks++; if (y8 !== e || err8 !== 1'b0) begin failures++; $display("FAIL rand_y n=%0d x=%0d t=%0d got y=%0d err=%b exp y=%0d err=0", nn, xx, tt, y8, err8, e); end
      checks++; if (cyc !== tt * 9 + 1 || ic8 !== 32'(tt)) begin failures++; $display("FAIL rand_timing t=%0d got cyc=%0d iter=%0d exp %0d/%0d", tt, cyc, ic8, tt * 9 + 1, tt); end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    logic [7:0] e;
    run8(8'd221, 8'd5, 32'd3, cyc, bc);
    n8 = 8'd199; x8 = 8'd11; t8 = 32'd2; start = 1'b1;
    @(negedge clk);
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL b2b_start_in_done got busy=%b exp=0", busy8); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy8 !== 1'b1) begin failures++; $display("FAIL b2b_accept got busy=%b exp=1", busy8); end
    wait_done8(cyc, bc);
    e = 8'(ref_pow(128'd199, 128'd11, 2));
    checks++; if (cyc !== 19 || y8 !== e) begin failures++; $display("FAIL b2b_result got cyc=%0d y=%0d exp 19/%0d", cyc, y8, e); end
  endtask

  task automatic test_ignore_start;
    int cyc, bc;
    @(negedge clk);
    n8 = 8'd221; x8 = 8'd5; t8 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n8 = 8'd251; x8 = 8'd3; t8 = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n8 = 8'd0; x8 = 8'd0; t8 = 32'd0;
    wait_done8(cyc, bc);
    cyc += 5;
    checks++; if (cyc !== 28 || y8 !== 8'd118 || ic8 !== 32'd3) begin failures++; $display("FAIL ignore_start got cyc=%0d y=%0d iter=%0d exp 28/118/3", cyc, y8, ic8); end
  endtask

  task automatic test_abort;
    logic [7:0] yp;
    logic [31:0] icp;
    logic dn;
    yp = y8;
    @(negedge clk);
    n8 = 8'd221; x8 = 8'd5; t8 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL abort_idle got busy=%b done=%b exp 0/0", busy8, done8); end
    checks++; if (ic8 !== 32'd1 || y8 !== yp) begin failures++; $display("FAIL abort_state got iter=%0d y=%0d exp 1/%0d", ic8, y8, yp); end
    icp = ic8;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    dn = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done8 || busy8) dn = 1'b1;
    end
    checks++; if (dn !== 1'b0 || ic8 !== icp || y8 !== yp) begin failures++; $display("FAIL abort_after got activity=%b iter=%0d y=%0d exp 0/%0d/%0d", dn, ic8, y8, icp, yp); end
  endtask

  task automatic test_abort_next;
    logic [7:0] yp;
    yp = y8;
    @(negedge clk);
    n8 = 8'd221; x8 = 8'd5; t8 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (26) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (done8 !== 1'b0 || busy8 !== 1'b0) begin failures++; $display("FAIL abort_next got done=%b busy=%b exp 0/0", done8, busy8); end
    checks++; if (ic8 !== 32'd2 || y8 !== yp) begin failures++; $display("FAIL abort_next_state got iter=%0d y=%0d exp 2/%0d", ic8, y8, yp); end
  endtask

  task automatic test_reset_midrun;
    int cyc, bc;
    run8(8'd221, 8'd5, 32'd3, cyc, bc);
    @(negedge clk);
    n8 = 8'd221; x8 = 8'd5; t8 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin failures++; $display("FAIL midreset_ctl got busy=%b done=%b exp 0/0", busy8, done8); end
    checks++; if (y8 !== 8'd0 || ic8 !== 32'd0 || err8 !== 1'b0) begin failures++; $display("FAIL midreset_data got y=%0d iter=%0d err=%b exp 0/0/0", y8, ic8, err8); end
    run8(8'd221, 8'd5, 32'd3, cyc, bc);
    checks++; if (cyc !== 28 || y8 !== 8'd118) begin failures++; $display("FAIL midreset_rerun got cyc=%0d y=%0d exp 28/118", cyc, y8); end
  endtask

  task automatic test_default_width;
    int cyc;
    logic [127:0] n, x, e;
    n = 128'he3e70682c2094cac629f6fbed82c07cd;
    run_w(n, 128'd2, 32'd1, cyc);
    checks++; if (cyc !== 130 || yw !== 128'd4) begin failures++; $display("FAIL wide_t1 got cyc=%0d y=%h exp 130/4", cyc, yw); end
    run_w(n, 128'd2, 32'd7, cyc);
    e = 128'h1c18f97d3df6b3539d60904127d3f833;
    checks++; if (cyc !== 904 || yw !== e || icw !== 32'd7) begin failures++; $display("FAIL wide_t7 got cyc=%0d y=%h iter=%0d exp 904/%h/7", cyc, yw, icw, e); end
    n = {$urandom, $urandom, $urandom, $urandom} | {1'b1, 126'b0, 1'b1};
    x = {$urandom, $urandom, $urandom, $urandom} % n;
    e = ref_pow(n, x, 2);
    run_w(n, x, 32'd2, cyc);
    checks++; if (cyc !== 259 || yw !== e || err_w !== 1'b0) begin failures++; $display("FAIL wide_rand got cyc=%0d y=%h err=%b exp 259/%h/0", cyc, yw, err_w, e); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; n8 = '0; x8 = '0; t8 = '0;
    start_w = 1'b0; abort_w = 1'b0; nw = '0; xw = '0; tw = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_basic();
    test_zero_iter_and_err();
    test_random();
    test_back_to_back();
    test_ignore_start();
    test_abort();
    test_abort_next();
    test_reset_midrun();
    test_default_width();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vdf_modsq_iter.md
Name: vdf_modsq_iter

Overview:
- Parametrised, runtime-programmable successor to the fixed-modulus VDF squarer.
- Computes y = x^(2^T) mod N for a modulus N, input x and iteration count T that are all loaded at start.
- Each squaring is a bit-serial interleaved multiply-reduce, one bit per cycle, so there is no wide combinational `*` or `%`.
- Sits under the VDF controller; start/done handshake; result held until the next start.

Parameters:
- MOD_LEN, 128, modulus/operand width in bits (>= 4).
- ITER_W, 32, width of the iteration count T.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch request; sampled only in IDLE
- modulus_in  in  MOD_LEN  modulus N; captured on accepted start
- x_in  in  MOD_LEN  base x; captured on accepted start
- iters_in  in  ITER_W  iteration count T; captured on accepted start
- abort  in  1  cancel the run in progress
- busy  out  1  high from the cycle after an accepted start until done or abort
- done  out  1  one-cycle completion pulse
- err  out  1  operand-error flag; valid with done; held until the next accepted start
- y_out  out  MOD_LEN  result; valid from done, held until the next accepted start
- iter_cnt  out  ITER_W  number of squarings completed in the current run

Behaviour:
- Reset values: busy=0, done=0, err=0, y_out=0, iter_cnt=0, state=IDLE.
- Reset mid-run: all of the above, with no done pulse.
- States: IDLE, MUL, NEXT, DONE.

IDLE:
- On start, capture N, x, T and clear iter_cnt and err.
- If N < 2 or x >= N: set err=1, go to DONE; y_out keeps its old value.
- Else if T == 0: y_out <= x, go to DONE.
- Else: acc <= 0, bit index b <= MOD_LEN-1, go to MUL.

MUL (exactly MOD_LEN cycles):
- Each cycle: t = 2*acc + (x[b] ? x : 0), computed MOD_LEN+2 bits wide.
- acc <= t - k*N, with k in {0,1,2} chosen so that the result < N.
- Decrement b. After b == 0 is processed, go to NEXT.

NEXT (1 cycle):
- x <= acc, iter_cnt <= iter_cnt+1.
- If iter_cnt+1 == T: y_out <= acc, go to DONE.
- Else: acc <= 0, b <= MOD_LEN-1, go to MUL.

DONE (1 cycle):
- done=1, busy=0, return to IDLE.

Timing:
- Latency, counting the start-sampling edge as cycle 0: done is high in cycle T*(MOD_LEN+1)+1.
- T == 0 or an error: done is high in cycle 1.
- busy is high in cycles 1 .. T*(MOD_LEN+1); it stays low for T == 0 and for errors.

Handshake and boundary rules:
- start is ignored whenever the state is not IDLE.
- start may be asserted in the DONE cycle but takes effect only from IDLE, i.e. the following cycle.
- abort in MUL or NEXT: IDLE on the next edge, no done, y_out and err unchanged, iter_cnt frozen.
- abort in IDLE or DONE has no effect.
- abort takes priority over the NEXT-to-DONE transition in the same cycle.
- iter_cnt does not wrap: T is at most 2^ITER_W - 1, and the comparison is on the full ITER_W-bit value.
- Invariant acc < N holds at every MUL step, which bounds t < 3N and guarantees k <= 2.

Optional Feature:
- Macro VDF_ITER_SNAPSHOT_EN.
- When defined, extra outputs are added:
  - snap_valid (1): one-cycle pulse in the cycle after each NEXT.
  - snap_val (MOD_LEN): the intermediate x^(2^i) mod N.
  - snap_idx (ITER_W): i, the updated iter_cnt.
- These let the controller checkpoint intermediate values for proof generation.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- MOD_LEN=8: N=221, x=5, T=3 -> done in cycle 28, y_out=118, err=0, iter_cnt=3. With snapshot enabled, snap_val sequence is 25, 183, 118.
- Default MOD_LEN=128: N=0xe3e70682c2094cac629f6fbed82c07cd, x=2.
  - T=1 -> y_out=4, done in cycle 130.
  - T=7 -> y_out=0x1c18f97d3df6b3539d60904127d3f833, done in cycle 904.
- MOD_LEN=8: N=221, x=7, T=0 -> done in cycle 1, y_out=7, busy never high. Separately, x=221 with N=221 -> done in cycle 1, err=1, y_out unchanged.
- MOD_LEN=8: start with T=3, abort in cycle 12 -> state IDLE by cycle 13, no done pulse, iter_cnt=1, y_out retains its prior value. A second start in cycle 5 of any run is ignored.
- Assert reset in cycle 15 of a T=3 run -> next cycle busy=0, done=0, y_out=0, iter_cnt=0. A fresh start afterwards gives the correct result (118).
